// File: rtl/hdc_pkg.sv
// Shared constants, verdict encodings and FSM state type for the HDC classifier.
package hdc_pkg;

    localparam int DIM        = 10000;
    localparam int CHUNK      = 16;
    localparam int NUM_CHUNKS = (DIM + CHUNK - 1) / CHUNK;
    localparam int CNT_W      = $clog2(DIM + 1);
    localparam int ADDR_W     = $clog2(NUM_CHUNKS);

    localparam logic [1:0] RES_HAM   = 2'b01;
    localparam logic [1:0] RES_SPAM  = 2'b00;
    localparam logic [1:0] RES_UNDEC = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/hv_popcount.sv
// Combinational population count of one CHUNK-bit word.
module hv_popcount #(
    parameter int W     = 16,
    parameter int OUT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits_i,
    output logic [OUT_W-1:0] count_o
);

    // Sum the set bits of the word.
    always_comb begin
        count_o = '0;
        for (int k = 0; k < W; k++) begin
            count_o = count_o + OUT_W'(bits_i[k]);
        end
    end

endmodule

// File: rtl/hv_hamming_classifier.sv
// Streams a message hypervector against ham/spam reference ROMs and emits a
// ham/spam/undecided verdict from the two accumulated Hamming distances.
module hv_hamming_classifier
    import hdc_pkg::*;
#(
    parameter int HV_DIM    = DIM,
    parameter int HV_CHUNK  = CHUNK,
    parameter int HV_CHUNKS = (HV_DIM + HV_CHUNK - 1) / HV_CHUNK,
    parameter int HV_CNT_W  = $clog2(HV_DIM + 1),
    parameter int HV_ADDR_W = (HV_CHUNKS > 1) ? $clog2(HV_CHUNKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [HV_CHUNK-1:0]  in_data,
    input  logic                 in_last,
    output logic                 ref_en,
    output logic [HV_ADDR_W-1:0] ref_addr,
    input  logic [HV_CHUNK-1:0]  ref_ham_data,
    input  logic [HV_CHUNK-1:0]  ref_spam_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [1:0]           result,
    output logic [HV_CNT_W-1:0]  count_ham,
    output logic [HV_CNT_W-1:0]  count_spam,
    output logic                 len_err
);

    // Valid bits in the final beat; the rest of that beat is padding.
    localparam int TAIL = HV_DIM - (HV_CHUNKS - 1) * HV_CHUNK;
    localparam int PC_W = $clog2(HV_CHUNK + 1);

    state_e                state_q, state_d;
    logic [HV_ADDR_W-1:0]  chunk_cnt_q, chunk_cnt_d;
    logic [HV_CHUNK-1:0]   beat_q, beat_d;
    logic                  stage_v_q, stage_v_d;
    logic                  stage_tail_q, stage_tail_d;
    logic                  len_flag_q, len_flag_d;
    logic [HV_CNT_W-1:0]   acc_ham_q, acc_ham_d;
    logic [HV_CNT_W-1:0]   acc_spam_q, acc_spam_d;
    logic                  in_ready_q, in_ready_d;
    logic                  result_valid_q, result_valid_d;
    logic [1:0]            result_q, result_d;
    logic [HV_CNT_W-1:0]   count_ham_q, count_ham_d;
    logic [HV_CNT_W-1:0]   count_spam_q, count_spam_d;
    logic                  len_err_q, len_err_d;

    logic                  accept_s;
    logic                  at_end_s;
    logic [HV_CHUNK-1:0]   mask_s;
    logic [HV_CHUNK-1:0]   diff_ham_s, diff_spam_s;
    logic [PC_W-1:0]       pc_ham_s, pc_spam_s;

    assign accept_s     = in_valid & in_ready_q;
    assign at_end_s     = (chunk_cnt_q == HV_ADDR_W'(HV_CHUNKS - 1));
    assign in_ready     = in_ready_q;
    assign ref_en       = accept_s;
    assign ref_addr     = chunk_cnt_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign count_ham    = count_ham_q;
    assign count_spam   = count_spam_q;
    assign len_err      = len_err_q;

    // Padding bits of the final beat never contribute to the distance.
    always_comb begin
        mask_s = '0;
        for (int k = 0; k < HV_CHUNK; k++) begin
            mask_s[k] = (!stage_tail_q) || (k < TAIL);
        end
    end

    assign diff_ham_s  = (beat_q ^ ref_ham_data)  & mask_s;
    assign diff_spam_s = (beat_q ^ ref_spam_data) & mask_s;

    hv_popcount #(.W(HV_CHUNK), .OUT_W(PC_W)) u_pc_ham (
        .bits_i  (diff_ham_s),
        .count_o (pc_ham_s)
    );

    hv_popcount #(.W(HV_CHUNK), .OUT_W(PC_W)) u_pc_spam (
        .bits_i  (diff_spam_s),
        .count_o (pc_spam_s)
    );

    // Next-state logic: beat capture, distance accumulation and verdict handshake.
    always_comb begin
        state_d        = state_q;
        chunk_cnt_d    = chunk_cnt_q;
        beat_d         = beat_q;
        stage_v_d      = 1'b0;
        stage_tail_d   = stage_tail_q;
        len_flag_d     = len_flag_q;
        result_valid_d = result_valid_q;
        result_d       = result_q;
        count_ham_d    = count_ham_q;
        count_spam_d   = count_spam_q;
        len_err_d      = len_err_q;

        // The stage drains its pending beat regardless of FSM state.
        if (stage_v_q) begin
            acc_ham_d  = acc_ham_q  + HV_CNT_W'(pc_ham_s);
            acc_spam_d = acc_spam_q + HV_CNT_W'(pc_spam_s);
        end else begin
            acc_ham_d  = acc_ham_q;
            acc_spam_d = acc_spam_q;
        end

        case (state_q)
            ST_RUN: begin
                if (accept_s) begin
                    beat_d       = in_data;
                    stage_v_d    = 1'b1;
                    stage_tail_d = at_end_s;
                    chunk_cnt_d  = chunk_cnt_q + HV_ADDR_W'(1);
                    if (in_last || at_end_s) begin
                        // Length is wrong unless in_last lands exactly on the final beat.
                        len_flag_d = in_last ^ at_end_s;
                        state_d    = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Final beat drains now; verdict registers load on the edge into CMP.
                count_ham_d    = acc_ham_d;
                count_spam_d   = acc_spam_d;
                len_err_d      = len_flag_q;
                result_valid_d = 1'b1;
                if (acc_ham_d < acc_spam_d) begin
                    result_d = RES_HAM;
                end else if (acc_ham_d > acc_spam_d) begin
                    result_d = RES_SPAM;
                end else begin
                    result_d = RES_UNDEC;
                end
                state_d = ST_CMP;
            end
            ST_CMP, ST_DONE: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    acc_ham_d      = '0;
                    acc_spam_d     = '0;
                    chunk_cnt_d    = '0;
                    state_d        = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        in_ready_d = (state_d == ST_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RUN;
            chunk_cnt_q    <= '0;
            beat_q         <= '0;
            stage_v_q      <= 1'b0;
            stage_tail_q   <= 1'b0;
            len_flag_q     <= 1'b0;
            acc_ham_q      <= '0;
            acc_spam_q     <= '0;
            in_ready_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= RES_SPAM;
            count_ham_q    <= '0;
            count_spam_q   <= '0;
            len_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            chunk_cnt_q    <= chunk_cnt_d;
            beat_q         <= beat_d;
            stage_v_q      <= stage_v_d;
            stage_tail_q   <= stage_tail_d;
            len_flag_q     <= len_flag_d;
            acc_ham_q      <= acc_ham_d;
            acc_spam_q     <= acc_spam_d;
            in_ready_q     <= in_ready_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            count_ham_q    <= count_ham_d;
            count_spam_q   <= count_spam_d;
            len_err_q      <= len_err_d;
        end
    end

endmodule
